life_engine: RTL and testbench

LIFE_ENGINE -- requirements
Module: life_engine

---
 rtl/life_engine.sv | 152 +++++++++++++++
 tb/tb_life_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// Conway-style cellular automaton engine: computes one grid row per clock into a
// shadow register, then commits the whole next generation in a single edge.
module life_engine #(
  parameter int         COLS    = 80,
  parameter int         ROWS    = 48,
  parameter int         WRAP    = 1,
  parameter logic [8:0] BIRTH   = 9'b000001000,
  parameter logic [8:0] SURVIVE = 9'b000001100,
  parameter int         GEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 tick,
  input  logic                 step,
  input  logic                 clear,
  input  logic                 set_valid,
  input  logic [7:0]           set_x,
  input  logic [7:0]           set_y,
  input  logic                 set_val,
  output logic                 set_ready,
  output logic [COLS*ROWS-1:0] grid,
  output logic                 busy,
  output logic                 gen_done,
  output logic [GEN_W-1:0]     generation,
  output logic                 stable
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t            state_reg, state_next;
  logic [COLS-1:0]   grid_reg   [ROWS];
  logic [COLS-1:0]   shadow_reg [ROWS];
  logic [RW-1:0]     r_reg;
  logic [GEN_W-1:0]  gen_reg;
  logic              stable_reg;
  logic              done_reg;

  logic              do_clear, do_write, do_start;
  logic              wr_in_range;
  logic [COLS-1:0]   prev_row, cur_row, next_row, new_row;
  logic [COLS*ROWS-1:0] shadow_flat;

  assign wr_in_range = ({1'b0, set_x} < 9'(COLS)) && ({1'b0, set_y} < 9'(ROWS));

  always_comb begin
    state_next = state_reg;
    do_clear   = 1'b0;
    do_write   = 1'b0;
    do_start   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear)
          do_clear = 1'b1;
        else if (set_valid)
          do_write = 1'b1;
        else if (step || (run && tick)) begin
          do_start   = 1'b1;
          state_next = CALC;
        end
      end
      CALC:    if (r_reg == RW'(ROWS - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rows above/below the one being computed; edge rows see wrap or dead space
  always_comb begin
    cur_row  = grid_reg[r_reg];
    prev_row = '0;
    next_row = '0;
    if (r_reg != '0)
      prev_row = grid_reg[r_reg - RW'(1)];
    else if (WRAP != 0)
      prev_row = grid_reg[RW'(ROWS - 1)];
    if (r_reg != RW'(ROWS - 1))
      next_row = grid_reg[r_reg + RW'(1)];
    else if (WRAP != 0)
      next_row = grid_reg[0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      localparam int LC = (gi == 0) ? COLS - 1 : gi - 1;
      localparam int RC = (gi == COLS - 1) ? 0 : gi + 1;
      localparam bit LV = (WRAP != 0) || (gi != 0);
      localparam bit RV = (WRAP != 0) || (gi != COLS - 1);
      logic [7:0] nbr;
      logic [3:0] cnt;
      assign nbr = {prev_row[gi], next_row[gi],
                    prev_row[LC] & LV, cur_row[LC] & LV, next_row[LC] & LV,
                    prev_row[RC] & RV, cur_row[RC] & RV, next_row[RC] & RV};
      assign cnt = 4'($countones(nbr));
      assign new_row[gi] = cur_row[gi] ? SURVIVE[cnt] : BIRTH[cnt];
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign grid[gi*COLS +: COLS]        = grid_reg[gi];
      assign shadow_flat[gi*COLS +: COLS] = shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      r_reg      <= '0;
      gen_reg    <= '0;
      stable_reg <= 1'b0;
      done_reg   <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        grid_reg[i]   <= '0;
        shadow_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      if (do_clear) begin
        for (int i = 0; i < ROWS; i++) grid_reg[i] <= '0;
        gen_reg    <= '0;
        stable_reg <= 1'b0;
      end
      if (do_write && wr_in_range) begin
        grid_reg[set_y[RW-1:0]][set_x[CW-1:0]] <= set_val;
        stable_reg <= 1'b0;
      end
      if (do_start)
        r_reg <= '0;
      if (state_reg == CALC) begin
        shadow_reg[r_reg] <= new_row;
        r_reg             <= r_reg + RW'(1);
      end
      if (state_reg == COMMIT) begin
        grid_reg   <= shadow_reg;
        gen_reg    <= gen_reg + GEN_W'(1);
        stable_reg <= (shadow_flat == grid);
        done_reg   <= 1'b1;
      end
    end
  end

  assign set_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign gen_done   = done_reg;
  assign generation = gen_reg;
  assign stable     = stable_reg;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench: default 80x48 toroidal engine plus a 6x6 dead-edge engine.
module tb_life_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tick;

  logic          d_run, d_step, d_clear, d_set_valid, d_set_val;
  logic [7:0]    d_set_x, d_set_y;
  logic          d_set_ready, d_busy, d_gen_done, d_stable;
  logic [3839:0] d_grid;
  logic [15:0]   d_generation;

  logic          s_step, s_clear, s_set_valid, s_set_val;
  logic [7:0]    s_set_x, s_set_y;
  logic          s_set_ready, s_busy, s_gen_done, s_stable;
  logic [35:0]   s_grid;
  logic [15:0]   s_generation;

  life_engine u_dut (
    .clk(clk), .reset(rst_n), .run(d_run), .tick(tick), .step(d_step), .clear(d_clear),
    .set_valid(d_set_valid), .set_x(d_set_x), .set_y(d_set_y), .set_val(d_set_val),
    .set_ready(d_set_ready), .grid(d_grid), .busy(d_busy), .gen_done(d_gen_done),
    .generation(d_generation), .stable(d_stable)
  );

  life_engine #(.COLS(6), .ROWS(6), .WRAP(0)) u_small (
    .clk(clk), .reset(rst_n), .run(1'b0), .tick(tick), .step(s_step), .clear(s_clear),
    .set_valid(s_set_valid), .set_x(s_set_x), .set_y(s_set_y), .set_val(s_set_val),
    .set_ready(s_set_ready), .grid(s_grid), .busy(s_busy), .gen_done(s_gen_done),
    .generation(s_generation), .stable(s_stable)
  );

  int checks = 0;
  int errors = 0;
  int d_done_cnt = 0;
  logic [3839:0] exp_g;
  logic [35:0]   exp_s;

  always @(negedge clk) if (d_gen_done) d_done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic g_set(input int x, input int y);
    exp_g[x + y*80] = 1'b1;
  endtask

  task automatic s_set(input int x, input int y);
    exp_s[x + y*6] = 1'b1;
  endtask

  function automatic int d_diff();
    return $countones(d_grid ^ exp_g);
  endfunction

  function automatic int s_diff();
    return $countones(s_grid ^ exp_s);
  endfunction

  task automatic d_write(input int x, input int y, input logic v);
    d_set_valid = 1'b1; d_set_x = 8'(x); d_set_y = 8'(y); d_set_val = v;
    nxt();
    d_set_valid = 1'b0;
  endtask

  task automatic s_write(input int x, input int y, input logic v);
    s_set_valid = 1'b1; s_set_x = 8'(x); s_set_y = 8'(y); s_set_val = v;
    nxt();
    s_set_valid = 1'b0;
  endtask

  task automatic d_pulse_step();
    d_step = 1'b1;
    nxt();
    d_step = 1'b0;
  endtask

  task automatic s_pulse_step();
    s_step = 1'b1;
    nxt();
    s_step = 1'b0;
  endtask

  task automatic d_wait_done(input string tag);
    int n = 0;
    while (!d_gen_done && n < 300) begin nxt(); n++; end
    check(tag, 32'(d_gen_done), 1);
  endtask

  task automatic s_wait_done(input string tag);
    int n = 0;
    while (!s_gen_done && n < 100) begin nxt(); n++; end
    check(tag, 32'(s_gen_done), 1);
  endtask

  task automatic d_wait_gen(input string tag, input int g);
    int n = 0;
    while (d_generation != 16'(g) && n < 3000) begin nxt(); n++; end
    check(tag, 32'(d_generation), 32'(g));
  endtask

  // Free-running generation-rate strobe, one pulse per 100 cycles
  initial begin
    tick = 1'b0;
    forever begin
      repeat (99) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    d_run = 0; d_step = 0; d_clear = 0; d_set_valid = 0; d_set_val = 0; d_set_x = 0; d_set_y = 0;
    s_step = 0; s_clear = 0; s_set_valid = 0; s_set_val = 0; s_set_x = 0; s_set_y = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(d_set_ready), 1);
    check("rst_busy", 32'(d_busy), 0);
    check("rst_gen", 32'(d_generation), 0);
    check("rst_pop", $countones(d_grid), 0);
    check("rst_done", 32'(d_gen_done), 0);
    check("rst_small_ready", 32'(s_set_ready), 1);
    rst_n = 1'b1;
    nxt();

    // Blinker: horizontal -> vertical after exactly ROWS+1 edges
    d_write(10, 5, 1); d_write(11, 5, 1); d_write(12, 5, 1);
    exp_g = '0; g_set(10, 5); g_set(11, 5); g_set(12, 5);
    check("blink_write", d_diff(), 0);
    d_pulse_step();
    check("blink_busy", 32'(d_busy), 1);
    repeat (48) nxt();
    check("blink_hold", d_diff(), 0);
    check("blink_busy48", 32'(d_busy), 1);
    nxt();
    exp_g = '0; g_set(11, 4); g_set(11, 5); g_set(11, 6);
    check("blink_grid", d_diff(), 0);
    check("blink_gen", 32'(d_generation), 1);
    check("blink_done", 32'(d_gen_done), 1);
    check("blink_idle", 32'(d_busy), 0);
    nxt();
    check("blink_done_low", 32'(d_gen_done), 0);
    check("blink_done_cnt", 32'(d_done_cnt), 1);
    check("blink_stable", 32'(d_stable), 0);

    // Out-of-range writes are dropped
    d_write(80, 0, 1); d_write(0, 48, 1);
    check("oor_grid", d_diff(), 0);

    d_clear = 1'b1; nxt(); d_clear = 1'b0;
    check("clr_pop", $countones(d_grid), 0);
    check("clr_gen", 32'(d_generation), 0);

    // Still life: block survives, stable rises
    d_write(0, 0, 1); d_write(1, 0, 1); d_write(0, 1, 1); d_write(1, 1, 1);
    exp_g = '0; g_set(0, 0); g_set(1, 0); g_set(0, 1); g_set(1, 1);
    d_pulse_step();
    d_wait_done("blk_done");
    check("blk_grid", d_diff(), 0);
    check("blk_stable", 32'(d_stable), 1);
    check("blk_gen", 32'(d_generation), 1);
    d_write(40, 20, 0);
    check("wr_clears_stable", 32'(d_stable), 0);

    // Requests during CALC are ignored and not queued
    d_pulse_step();
    repeat (5) nxt();
    check("bsy_ready", 32'(d_set_ready), 0);
    d_set_valid = 1'b1; d_set_x = 8'd30; d_set_y = 8'd30; d_set_val = 1'b1;
    d_clear = 1'b1; d_step = 1'b1;
    nxt();
    d_set_valid = 1'b0; d_clear = 1'b0; d_step = 1'b0;
    check("bsy_hold", d_diff(), 0);
    check("bsy_gen_hold", 32'(d_generation), 1);
    d_wait_done("bsy_done");
    check("bsy_gen", 32'(d_generation), 2);
    check("bsy_grid", d_diff(), 0);
    repeat (80) nxt();
    check("bsy_noqueue_gen", 32'(d_generation), 2);
    check("bsy_noqueue_busy", 32'(d_busy), 0);

    // Asynchronous reset while CALC is at r=20
    d_pulse_step();
    repeat (20) nxt();
    rst_n = 1'b0;
    #1;
    check("arst_pop", $countones(d_grid), 0);
    check("arst_busy", 32'(d_busy), 0);
    check("arst_gen", 32'(d_generation), 0);
    check("arst_ready", 32'(d_set_ready), 1);
    repeat (3) nxt();
    rst_n = 1'b1;
    repeat (60) nxt();
    check("arst_no_done", 32'(d_done_cnt), 3);

    // clear wins over write and step in the same cycle
    d_write(20, 20, 1); d_write(21, 20, 1); d_write(20, 21, 1); d_write(21, 21, 1);
    d_pulse_step();
    d_wait_done("pri_setup_done");
    check("pri_setup_gen", 32'(d_generation), 1);
    d_clear = 1'b1; d_set_valid = 1'b1; d_set_x = 8'd3; d_set_y = 8'd3; d_set_val = 1'b1; d_step = 1'b1;
    nxt();
    d_clear = 1'b0; d_set_valid = 1'b0; d_step = 1'b0;
    check("pri_pop", $countones(d_grid), 0);
    check("pri_gen", 32'(d_generation), 0);
    check("pri_busy", 32'(d_busy), 0);

    // Glider crosses the (79,47) corner on the torus under run/tick
    d_write(78, 45, 1); d_write(79, 46, 1); d_write(77, 47, 1); d_write(78, 47, 1); d_write(79, 47, 1);
    d_run = 1'b1;
    d_wait_gen("gl_gen4", 4);
    exp_g = '0; g_set(79, 46); g_set(0, 47); g_set(78, 0); g_set(79, 0); g_set(0, 0);
    check("gl_grid4", d_diff(), 0);
    d_wait_gen("gl_gen12", 12);
    d_run = 1'b0;
    exp_g = '0; g_set(1, 0); g_set(2, 1); g_set(0, 2); g_set(1, 2); g_set(2, 2);
    check("gl_grid12", d_diff(), 0);
    check("gl_pop", $countones(d_grid), 5);

    // Dead-edge 6x6: glider runs into the corner and freezes as a block
    s_write(1, 0, 1); s_write(2, 1, 1); s_write(0, 2, 1); s_write(1, 2, 1); s_write(2, 2, 1);
    for (int g = 1; g <= 16; g++) begin
      s_pulse_step();
      s_wait_done("sm_done");
      if (g == 12) begin
        exp_s = '0; s_set(4, 3); s_set(5, 4); s_set(3, 5); s_set(4, 5); s_set(5, 5);
        check("sm_grid12", s_diff(), 0);
      end
    end
    exp_s = '0; s_set(4, 4); s_set(5, 4); s_set(4, 5); s_set(5, 5);
    check("sm_grid16", s_diff(), 0);
    check("sm_stable", 32'(s_stable), 1);
    check("sm_gen", 32'(s_generation), 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
